// File: rtl/core_stage_sequencer_if.sv
// Handshake bundle between the stage sequencer and the core's stage units.
// master = sequencer side, slave = stage/control side.
interface core_stage_sequencer_if #(
    parameter int CNT_W = 32
);
    logic             start;
    logic             halt_req;
    logic             fetch_en;
    logic             fetch_done;
    logic             decode_en;
    logic             decode_done;
    logic             needs_mem;
    logic             writes_reg;
    logic             exec_en;
    logic             exec_done;
    logic             mem_en;
    logic             mem_done;
    logic             trap;
    logic             wb_en;
    logic             wb_done;
    logic             trap_take;
    logic             retire;
    logic [CNT_W-1:0] retired;
    logic [2:0]       stage;
    logic             halted;
    logic             timeout_err;

    modport master (
        input  start, halt_req, fetch_done, decode_done, needs_mem, writes_reg,
               exec_done, mem_done, trap, wb_done,
        output fetch_en, decode_en, exec_en, mem_en, wb_en, trap_take, retire,
               retired, stage, halted, timeout_err
    );

    modport slave (
        output start, halt_req, fetch_done, decode_done, needs_mem, writes_reg,
               exec_done, mem_done, trap, wb_done,
        input  fetch_en, decode_en, exec_en, mem_en, wb_en, trap_take, retire,
               retired, stage, halted, timeout_err
    );
endinterface

// File: rtl/core_stage_sequencer.sv
// Multi-cycle instruction sequencer: F/D/E/M/W stepping with en pulses, trap,
// debug halt at instruction boundaries, per-stage watchdog and retire counter.
module core_stage_sequencer #(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 1024,
    parameter int TMR_W   = 16
) (
    input  logic clk,
    input  logic rstn,
    core_stage_sequencer_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_F    = 3'd1,
        S_D    = 3'd2,
        S_E    = 3'd3,
        S_M    = 3'd4,
        S_W    = 3'd5,
        S_TRAP = 3'd6,
        S_HALT = 3'd7
    } state_t;

    localparam bit              WD_ON   = (TIMEOUT > 0);
    localparam logic [TMR_W-1:0] WD_LAST = TMR_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t             state_reg, state_next, boundary_state;
    logic [4:0]         en_reg, en_next;
    logic               trap_take_reg, trap_take_next;
    logic               retire_reg, retire_next;
    logic [CNT_W-1:0]   retired_reg;
    logic               halted_reg, halted_next;
    logic               terr_reg, terr_next;
    logic               mem_flag_reg, mem_flag_next;
    logic               wb_flag_reg, wb_flag_next;
    logic [TMR_W-1:0]   wdog_reg, wdog_next;
    logic               cur_done, done_ok, stage_active, expire, entering;

    always_comb begin
        cur_done = 1'b0;
        case (state_reg)
            S_F:     cur_done = bus.fetch_done;
            S_D:     cur_done = bus.decode_done;
            S_E:     cur_done = bus.exec_done;
            S_M:     cur_done = bus.mem_done;
            S_W:     cur_done = bus.wb_done;
            default: cur_done = 1'b0;
        endcase
    end

    // A done coinciding with the stage's own en pulse is too early to count.
    assign done_ok      = cur_done && !(|en_reg);
    assign stage_active = (state_reg >= S_F) && (state_reg <= S_W);
    assign expire       = WD_ON && stage_active && !done_ok && (wdog_reg == WD_LAST);

    always_comb begin
        state_next     = state_reg;
        retire_next    = 1'b0;
        terr_next      = terr_reg;
        mem_flag_next  = mem_flag_reg;
        wb_flag_next   = wb_flag_reg;
        boundary_state = bus.halt_req ? S_HALT : S_F;
        case (state_reg)
            S_IDLE, S_HALT: if (bus.start) state_next = S_F;
            S_F: if (done_ok) state_next = S_D;
            S_D: if (done_ok) begin
                state_next    = S_E;
                mem_flag_next = bus.needs_mem;
                wb_flag_next  = bus.writes_reg;
            end
            S_E: if (done_ok) begin
                if (bus.trap)          state_next = S_TRAP;
                else if (mem_flag_reg) state_next = S_M;
                else if (wb_flag_reg)  state_next = S_W;
                else begin
                    retire_next = 1'b1;
                    state_next  = boundary_state;
                end
            end
            S_M: if (done_ok) begin
                if (bus.trap)         state_next = S_TRAP;
                else if (wb_flag_reg) state_next = S_W;
                else begin
                    retire_next = 1'b1;
                    state_next  = boundary_state;
                end
            end
            S_W: if (done_ok) begin
                retire_next = 1'b1;
                state_next  = boundary_state;
            end
            S_TRAP:  state_next = boundary_state;
            default: state_next = S_IDLE;
        endcase
        if (expire) begin
            state_next = S_HALT;
            terr_next  = 1'b1;
        end
    end

    assign entering       = (state_next != state_reg);
    assign trap_take_next = (state_next == S_TRAP);
    assign halted_next    = (state_next == S_HALT);
    assign wdog_next      = (entering || !stage_active) ? '0 : wdog_reg + 1'b1;

    // en bit gi belongs to stage state gi+1 (F..W)
    generate
        for (genvar gi = 0; gi < 5; gi++) begin : g_en
            assign en_next[gi] = entering && (state_next == state_t'(3'(gi + 1)));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_reg     <= S_IDLE;
            en_reg        <= '0;
            trap_take_reg <= 1'b0;
            retire_reg    <= 1'b0;
            retired_reg   <= '0;
            halted_reg    <= 1'b0;
            terr_reg      <= 1'b0;
            mem_flag_reg  <= 1'b0;
            wb_flag_reg   <= 1'b0;
            wdog_reg      <= '0;
        end else begin
            state_reg     <= state_next;
            en_reg        <= en_next;
            trap_take_reg <= trap_take_next;
            retire_reg    <= retire_next;
            halted_reg    <= halted_next;
            terr_reg      <= terr_next;
            mem_flag_reg  <= mem_flag_next;
            wb_flag_reg   <= wb_flag_next;
            wdog_reg      <= wdog_next;
            if (retire_next) retired_reg <= retired_reg + 1'b1;
        end
    end

    assign bus.fetch_en    = en_reg[0];
    assign bus.decode_en   = en_reg[1];
    assign bus.exec_en     = en_reg[2];
    assign bus.mem_en      = en_reg[3];
    assign bus.wb_en       = en_reg[4];
    assign bus.trap_take   = trap_take_reg;
    assign bus.retire      = retire_reg;
    assign bus.retired     = retired_reg;
    assign bus.stage       = state_reg;
    assign bus.halted      = halted_reg;
    assign bus.timeout_err = terr_reg;
endmodule

// File: tb/tb_core_stage_sequencer.sv
// Randomized bench: plans each instruction (path, per-stage done delays) and
// predicts the sequencer's visible behaviour cycle by cycle from that plan.
module tb_core_stage_sequencer;
    localparam int CNT_W   = 4;
    localparam int TIMEOUT = 8;
    localparam int TMR_W   = 16;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    core_stage_sequencer_if #(.CNT_W(CNT_W)) bus ();

    core_stage_sequencer #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .TMR_W(TMR_W)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int model_retired = 0;
    bit model_terr    = 1'b0;
    bit allow_halt    = 1'b1;
    bit allow_trap    = 1'b1;
    bit allow_timeout = 1'b1;
    int force_dd      = -1;
    bit hr_seen       = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic clear_inputs();
        bus.start = 1'b0;       bus.halt_req = 1'b0;
        bus.fetch_done = 1'b0;  bus.decode_done = 1'b0;
        bus.exec_done = 1'b0;   bus.mem_done = 1'b0;   bus.wb_done = 1'b0;
        bus.needs_mem = 1'b0;   bus.writes_reg = 1'b0; bus.trap = 1'b0;
    endtask

    // Everything random; callers override what matters for the current cycle.
    task automatic rand_inputs();
        bus.start       = ($urandom & 32'd1) != 0;
        bus.halt_req    = allow_halt && ($urandom_range(0, 4) == 0);
        bus.fetch_done  = ($urandom & 32'd1) != 0;
        bus.decode_done = ($urandom & 32'd1) != 0;
        bus.exec_done   = ($urandom & 32'd1) != 0;
        bus.mem_done    = ($urandom & 32'd1) != 0;
        bus.wb_done     = ($urandom & 32'd1) != 0;
        bus.needs_mem   = ($urandom & 32'd1) != 0;
        bus.writes_reg  = ($urandom & 32'd1) != 0;
        bus.trap        = ($urandom & 32'd1) != 0;
    endtask

    task automatic set_done(input int code, input logic v);
        case (code)
            1: bus.fetch_done  = v;
            2: bus.decode_done = v;
            3: bus.exec_done   = v;
            4: bus.mem_done    = v;
            5: bus.wb_done     = v;
            default: ;
        endcase
    endtask

    function automatic int rand_delay();
        int r = $urandom_range(0, 99);
        if (allow_timeout && r < 5) return $urandom_range(TIMEOUT, TIMEOUT + 2);
        if (r < 20) return $urandom_range(4, TIMEOUT - 1);
        return $urandom_range(1, 3);
    endfunction

    task automatic check_state(input string tag, input int code, input bit first,
                               input bit exp_retire, input bit exp_trap);
        logic [4:0] en_exp;
        logic [4:0] en_obs;
        en_exp = '0;
        if (first && code >= 1 && code <= 5) en_exp[code-1] = 1'b1;
        en_obs = {bus.wb_en, bus.mem_en, bus.exec_en, bus.decode_en, bus.fetch_en};
        check_val({tag, ".stage"},   32'(bus.stage),       32'(code));
        check_val({tag, ".en"},      32'(en_obs),          32'(en_exp));
        check_val({tag, ".retire"},  32'(bus.retire),      32'(exp_retire));
        check_val({tag, ".trap"},    32'(bus.trap_take),   32'(exp_trap));
        check_val({tag, ".halted"},  32'(bus.halted),      32'(code == 7));
        check_val({tag, ".terr"},    32'(bus.timeout_err), 32'(model_terr));
        check_val({tag, ".retired"}, 32'(bus.retired),     32'(model_retired));
    endtask

    // Done for this stage arrives d cycles after its en; a done in the en
    // cycle itself may be thrown in at random and must be ignored.
    task automatic run_stage(input int code, input int d, input bit f_mem, input bit f_wb,
                             input bit f_trap, output bit done_hit);
        done_hit = 1'b0;
        for (int i = 1; i <= TIMEOUT; i++) begin
            rand_inputs();
            if (i == 1) set_done(code, ($urandom & 32'd1) != 0);
            else        set_done(code, i == d + 1);
            if (i == d + 1 && i > 1) begin
                bus.needs_mem  = f_mem;
                bus.writes_reg = f_wb;
                bus.trap       = f_trap;
            end
            hr_seen = bus.halt_req;
            tick();
            if (i == d + 1 && i > 1) begin
                done_hit = 1'b1;
                return;
            end
            if (i < TIMEOUT) check_state("in_stage", code, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic resume();
        int w = $urandom_range(0, 3);
        for (int k = 0; k < w; k++) begin
            rand_inputs();
            bus.start = 1'b0;
            tick();
            check_state("hold", 7, 1'b0, 1'b0, 1'b0);
        end
        rand_inputs();
        bus.start = 1'b1;
        tick();
        check_state("restart", 1, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic boundary(input bit hr, input bit did_retire);
        if (did_retire) model_retired = (model_retired + 1) % (1 << CNT_W);
        if (hr) begin
            check_state("halt_entry", 7, 1'b0, did_retire, 1'b0);
            resume();
        end else begin
            check_state("next_fetch", 1, 1'b1, did_retire, 1'b0);
        end
    endtask

    task automatic timed_out(input int n, input string where);
        model_terr = 1'b1;
        $display("instr %0d: watchdog expired in %s", n, where);
        check_state("timeout", 7, 1'b0, 1'b0, 1'b0);
        resume();
    endtask

    task automatic take_trap(input int n, input string where);
        bit hr;
        check_state("trap_entry", 6, 1'b0, 1'b0, 1'b1);
        rand_inputs();
        hr = bus.halt_req;
        tick();
        $display("instr %0d: trap taken from %s, halt=%0d", n, where, hr);
        boundary(hr, 1'b0);
    endtask

    task automatic run_instr(input int n);
        bit f_mem, f_wb, te, tm, ok;
        int dd;
        f_mem = ($urandom & 32'd1) != 0;
        f_wb  = ($urandom & 32'd1) != 0;
        te    = allow_trap && ($urandom_range(0, 7) == 0);
        tm    = allow_trap && f_mem && ($urandom_range(0, 5) == 0);
        run_stage(1, rand_delay(), 1'b0, 1'b0, 1'b0, ok);
        if (!ok) begin timed_out(n, "F"); return; end
        check_state("d_entry", 2, 1'b1, 1'b0, 1'b0);
        dd = (force_dd >= 0) ? force_dd : rand_delay();
        run_stage(2, dd, f_mem, f_wb, 1'b0, ok);
        if (!ok) begin timed_out(n, "D"); return; end
        check_state("e_entry", 3, 1'b1, 1'b0, 1'b0);
        run_stage(3, rand_delay(), 1'b0, 1'b0, te, ok);
        if (!ok) begin timed_out(n, "E"); return; end
        if (te) begin take_trap(n, "E"); return; end
        if (f_mem) begin
            check_state("m_entry", 4, 1'b1, 1'b0, 1'b0);
            run_stage(4, rand_delay(), 1'b0, 1'b0, tm, ok);
            if (!ok) begin timed_out(n, "M"); return; end
            if (tm) begin take_trap(n, "M"); return; end
        end
        if (f_wb) begin
            check_state("w_entry", 5, 1'b1, 1'b0, 1'b0);
            run_stage(5, rand_delay(), 1'b0, 1'b0, 1'b0, ok);
            if (!ok) begin timed_out(n, "W"); return; end
        end
        $display("instr %0d: retire mem=%0d wb=%0d halt=%0d", n, f_mem, f_wb, hr_seen);
        boundary(hr_seen, 1'b1);
    endtask

    task automatic do_reset(input string tag);
        rand_inputs();
        rstn = 1'b0;
        tick();
        model_retired = 0;
        model_terr    = 1'b0;
        check_state(tag, 0, 1'b0, 1'b0, 1'b0);
        rstn = 1'b1;
        rand_inputs();
        bus.start = 1'b1;
        tick();
        check_state("start", 1, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        bit ok;
        clear_inputs();
        rstn = 1'b0;
        tick();
        tick();
        check_state("reset", 0, 1'b0, 1'b0, 1'b0);
        rstn = 1'b1;
        for (int k = 0; k < 3; k++) begin
            rand_inputs();
            bus.start = 1'b0;
            tick();
            check_state("idle", 0, 1'b0, 1'b0, 1'b0);
        end
        rand_inputs();
        bus.start = 1'b1;
        tick();
        check_state("start", 1, 1'b1, 1'b0, 1'b0);

        for (int n = 0; n < 150; n++) run_instr(n);

        // Reset while a store sits in the mem stage.
        allow_halt = 1'b0;
        allow_trap = 1'b0;
        allow_timeout = 1'b0;
        run_stage(1, 1, 1'b0, 1'b0, 1'b0, ok);
        check_state("d_entry", 2, 1'b1, 1'b0, 1'b0);
        run_stage(2, 1, 1'b1, 1'b0, 1'b0, ok);
        check_state("e_entry", 3, 1'b1, 1'b0, 1'b0);
        run_stage(3, 1, 1'b0, 1'b0, 1'b0, ok);
        check_state("m_entry", 4, 1'b1, 1'b0, 1'b0);
        $display("reset asserted during mem stage");
        do_reset("reset_mid_mem");

        // Decode done in the last allowed cycle, then one cycle too late.
        force_dd = TIMEOUT - 1;
        run_instr(1000);
        force_dd = TIMEOUT;
        run_instr(1001);
        force_dd = -1;

        // Counter wraps after 2^CNT_W retires.
        do_reset("reset_before_wrap");
        for (int n = 0; n < 16; n++) run_instr(2000 + n);
        check_val("wrap", 32'(bus.retired), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
